// File: rtl/float_to_int_nb.sv
// float_to_int_nb: two-stage float to signed integer converter.
// Rounds half away from zero and saturates, with valid/ready handshakes on both ports.
module float_to_int_nb #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int INT_W = 16
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [INT_W-1:0]     out_data,
  output logic                 out_ovf
);

  localparam int SH_W = $clog2(INT_W);
  localparam int WIDE = MAN_W + INT_W;

  localparam logic [EXP_W:0] BIAS =
    {2'b00, {(EXP_W-1){1'b1}}};
  localparam logic signed [EXP_W:0] E_OVF =
    (EXP_W+1)'(INT_W);
  localparam logic signed [EXP_W:0] E_HALF = '1;

  localparam logic [INT_W:0] POS_MAX =
    {2'b00, {(INT_W-1){1'b1}}};
  localparam logic [INT_W:0] NEG_MAX =
    {2'b01, {(INT_W-1){1'b0}}};

  typedef enum logic [1:0] {
    C_ZERO, C_NORM, C_INF, C_NAN
  } cls_t;

  typedef struct packed {
    logic             sign;
    logic [EXP_W:0]   e;
    cls_t             cls;
    logic [MAN_W-1:0] man;
  } s1_t;

  logic             s1_v;
  logic             s2_v;
  s1_t              s1_d;
  s1_t              s1_q;
  logic             s2_load;
  logic             in_fire;
  logic [EXP_W-1:0] f_exp;
  logic [MAN_W-1:0] f_man;

  logic signed [EXP_W:0] e;
  logic [WIDE-1:0]       wide;
  logic [WIDE-1:0]       shifted;
  logic [INT_W:0]        mag;
  logic                  big;
  logic [INT_W-1:0]      res;
  logic                  ovf;

  assign s2_load   = s1_v && (!s2_v || out_ready);
  assign in_ready  = !s1_v || s2_load;
  assign in_fire   = in_valid && in_ready;
  assign out_valid = s2_v;

  assign f_exp = in_data[EXP_W+MAN_W-1:MAN_W];
  assign f_man = in_data[MAN_W-1:0];

  // S1 unpack: unbiased exponent and value class
  always_comb begin
    s1_d      = '0;
    s1_d.sign = in_data[EXP_W+MAN_W];
    s1_d.e    = {1'b0, f_exp} - BIAS;
    s1_d.man  = f_man;
    unique case (1'b1)
      (f_exp == '0):
        s1_d.cls = C_ZERO;
      (f_exp == '1 && f_man == '0):
        s1_d.cls = C_INF;
      (f_exp == '1 && f_man != '0):
        s1_d.cls = C_NAN;
      default:
        s1_d.cls = C_NORM;
    endcase
  end

  // S2 shift, round, sign and saturate
  always_comb begin
    e       = $signed(s1_q.e);
    big     = 1'b0;
    mag     = '0;
    res     = '0;
    ovf     = 1'b0;
    wide    = {{(INT_W-1){1'b0}}, 1'b1, s1_q.man};
    shifted = wide << e[SH_W-1:0];
    unique case (1'b1)
      (s1_q.cls == C_INF):
        big = 1'b1;
      (s1_q.cls == C_NORM && !e[EXP_W]
        && e >= E_OVF):
        big = 1'b1;
      (s1_q.cls == C_NORM && !e[EXP_W]
        && e < E_OVF):
        mag = {1'b0, shifted[WIDE-1:MAN_W]}
            + (INT_W+1)'(shifted[MAN_W-1]);
      (s1_q.cls == C_NORM && e == E_HALF):
        mag = (INT_W+1)'(1);
      default: ;
    endcase
    if (s1_q.cls == C_NAN) begin
      ovf = 1'b1;
    end else if (!s1_q.sign) begin
      if (big || mag > POS_MAX) begin
        res = POS_MAX[INT_W-1:0];
        ovf = 1'b1;
      end else begin
        res = mag[INT_W-1:0];
      end
    end else begin
      if (big || mag > NEG_MAX) begin
        res = NEG_MAX[INT_W-1:0];
        ovf = 1'b1;
      end else begin
        res = -mag[INT_W-1:0];
      end
    end
  end

  // pipeline registers and stage valids
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      s1_v     <= 1'b0;
      s2_v     <= 1'b0;
      s1_q     <= '0;
      out_data <= '0;
      out_ovf  <= 1'b0;
    end else begin
      if (in_fire) begin
        s1_v <= 1'b1;
        s1_q <= s1_d;
      end else if (s2_load) begin
        s1_v <= 1'b0;
      end
      if (s2_load) begin
        s2_v     <= 1'b1;
        out_data <= res;
        out_ovf  <= ovf;
      end else if (out_ready) begin
        s2_v <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_float_to_int_nb.sv
// tb_float_to_int_nb: directed and throttled random checks
// for the float to int converter.
module tb_float_to_int_nb;

  localparam int NV    = 16;
  localparam int NRAND = 400;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_data;
  logic        out_ovf;

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] vin [NV] = '{
    32'h3FC00000, 32'hC0200000, 32'h3F000000,
    32'h3EFAE148, 32'h471C4000, 32'hC7000000,
    32'hC7000100, 32'h7F800000, 32'hFF800000,
    32'h7FC00000, 32'h80000000, 32'h00000001,
    32'hC2F6CCCD, 32'h46FFFE00, 32'h46FFFF00,
    32'h47800000};
  logic [15:0] vexp [NV] = '{
    16'h0002, 16'hFFFD, 16'h0001,
    16'h0000, 16'h7FFF, 16'h8000,
    16'h8000, 16'h7FFF, 16'h8000,
    16'h0000, 16'h0000, 16'h0000,
    16'hFF85, 16'h7FFF, 16'h7FFF,
    16'h7FFF};
  logic vovf [NV] = '{
    1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
    1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0,
    1'b0, 1'b0, 1'b1, 1'b1};

  logic [16:0] q [$];
  logic [16:0] m;
  int          got;
  int          sent;
  int          cyc;
  logic        acc;

  float_to_int_nb dut (
    .clk       (clk),
    .nrst      (nrst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ovf   (out_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag,
                         input logic [15:0] d,
                         input logic o);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_data"}, 32'(out_data), 32'(d));
    chk({tag, "_ovf"}, 32'(out_ovf), 32'(o));
  endtask

  // independent model: floor(|x| + 0.5) in 64-bit integers
  function automatic logic [16:0] model(
    input logic [31:0] f);
    int     ex;
    longint sig;
    longint mag;
    ex  = int'(f[30:23]) - 127;
    sig = longint'({1'b1, f[22:0]});
    if (f[30:23] == 8'h00) return 17'h0;
    if (f[30:23] == 8'hFF) begin
      if (f[22:0] != 0) return 17'h10000;
      mag = 64'sd1 << 20;
    end else if (ex > 15) begin
      mag = 64'sd1 << 20;
    end else if (ex < -1) begin
      mag = 0;
    end else begin
      mag = ((sig << (ex + 1)) + (64'sd1 << 23)) >>> 24;
    end
    if (!f[31]) begin
      if (mag > 32767) return 17'h17FFF;
      return {1'b0, 16'(mag)};
    end
    if (mag > 32768) return 17'h18000;
    return {1'b0, 16'(-mag)};
  endfunction

  function automatic logic [31:0] rand_float();
    logic [7:0]  ex;
    logic [22:0] mn;
    int          r;
    r  = $urandom_range(0, 15);
    mn = 23'($urandom);
    if (r == 0) ex = 8'h00;
    else if (r <= 2) ex = 8'hFF;
    else ex = 8'($urandom_range(122, 145));
    if (r == 2) mn = '0;
    return {1'($urandom_range(0, 1)), ex, mn};
  endfunction

  initial begin
    // reset state
    #2;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_ovf", 32'(out_ovf), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    nrst = 1'b1;
    chk("rel_in_ready", 32'(in_ready), 32'd1);

    // back-to-back stream, two-cycle latency
    out_ready = 1'b1;
    for (int n = 0; n < NV + 3; n++) begin
      @(negedge clk);
      if (n >= 2 && n - 2 < NV)
        chk_out($sformatf("vec%0d", n - 2),
                vexp[n-2], vovf[n-2]);
      else
        chk("stream_idle", 32'(out_valid), 32'd0);
      if (n < NV) begin
        chk("stream_rdy", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_data  = vin[n];
      end else begin
        in_valid = 1'b0;
      end
    end

    // backpressure: two held, third stalls
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h40400000;
    chk("bp_rdy0", 32'(in_ready), 32'd1);
    @(negedge clk);
    chk("bp_rdy1", 32'(in_ready), 32'd1);
    in_data = 32'h40800000;
    @(negedge clk);
    chk("bp_rdy2", 32'(in_ready), 32'd0);
    chk_out("bp_hold", 16'd3, 1'b0);
    in_data = 32'h40A00000;
    @(negedge clk);
    chk("bp_rdy3", 32'(in_ready), 32'd0);
    chk_out("bp_hold2", 16'd3, 1'b0);
    out_ready = 1'b1;
    #1;
    chk("bp_rdy_rel", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    chk_out("bp_o4", 16'd4, 1'b0);
    @(negedge clk);
    chk_out("bp_o5", 16'd5, 1'b0);
    @(negedge clk);
    chk("bp_drain", 32'(out_valid), 32'd0);

    // asynchronous reset with two in flight
    in_valid = 1'b1;
    in_data  = 32'h40400000;
    @(negedge clk);
    in_data  = 32'h40800000;
    @(negedge clk);
    in_valid = 1'b0;
    chk("mr_pre_valid", 32'(out_valid), 32'd1);
    #2 nrst = 1'b0;
    #1;
    chk("mr_out_valid", 32'(out_valid), 32'd0);
    chk("mr_in_ready", 32'(in_ready), 32'd1);
    chk("mr_out_data", 32'(out_data), 32'd0);
    @(negedge clk);
    nrst     = 1'b1;
    in_valid = 1'b1;
    in_data  = 32'h40E00000;
    @(negedge clk);
    in_valid = 1'b0;
    chk("mr_lat", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk_out("mr_o7", 16'd7, 1'b0);
    @(negedge clk);
    chk("mr_single", 32'(out_valid), 32'd0);

    // throttled random traffic against the model
    got  = 0;
    sent = 0;
    cyc  = 0;
    acc  = 1'b0;
    while (got < NRAND && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (acc) in_valid = 1'b0;
      acc = 1'b0;
      out_ready = ($urandom_range(0, 3) != 0);
      if (!in_valid && sent < NRAND
          && $urandom_range(0, 2) != 0) begin
        in_valid = 1'b1;
        in_data  = rand_float();
      end
      #1;
      if (out_valid && out_ready) begin
        got++;
        chk("rnd_q", 32'(q.size() > 0), 32'd1);
        if (q.size() > 0) begin
          m = q.pop_front();
          chk($sformatf("rnd%0d", got),
              32'({out_ovf, out_data}), 32'(m));
        end
      end
      if (in_valid && in_ready) begin
        q.push_back(model(in_data));
        sent++;
        acc = 1'b1;
      end
    end
    chk("rnd_count", 32'(got), 32'(NRAND));
    chk("rnd_left", 32'(q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
